// File: rtl/m706_rx_if.sv
// m706_rx_if: serial line, baud clock, IOT clear and character status bundle for the console receiver.
interface m706_rx_if #(parameter int DATA_BITS = 8);
  logic                 baud_clk;
  logic                 ser_in;
  logic                 clr_flag;
  logic [DATA_BITS-1:0] data;
  logic                 flag;
  logic                 framing_err;
  logic                 overrun;
  logic                 active;
  modport master (output baud_clk, ser_in, clr_flag, input data, flag, framing_err, overrun, active);
  modport slave  (input baud_clk, ser_in, clr_flag, output data, flag, framing_err, overrun, active);
endinterface

// File: rtl/m706_rx.sv
// m706_rx: oversampling serial teletype receiver with ready flag, framing and overrun status.
module m706_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input logic        clk,
  input logic        rst_n,
  m706_rx_if.slave   bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state, state_n;
  logic [2:0]           bsync;
  logic [1:0]           rsync;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_q;
  logic                 flag_q, ferr_q, ovr_q;
  logic                 tick, rx, load;
  // bsync[2] is the previous synchronized level, used only for rising-edge detection
  assign tick            = bsync[1] & ~bsync[2];
  assign rx              = rsync[1];
  assign bus.data        = data_q;
  assign bus.flag        = flag_q;
  assign bus.framing_err = ferr_q;
  assign bus.overrun     = ovr_q;
  assign bus.active      = state != IDLE;
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    load    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          state_n = rx ? IDLE : START;
          tcnt_n  = '0;
        end
        START: begin
          tcnt_n = (tcnt == T_MID) ? '0 : tcnt + 1'b1;
          bcnt_n = '0;
          if (tcnt == T_MID) state_n = rx ? IDLE : DATA;
        end
        DATA: begin
          tcnt_n = (tcnt == T_END) ? '0 : tcnt + 1'b1;
          if (tcnt == T_END) begin
            shreg_n = {rx, shreg[DATA_BITS-1:1]};
            bcnt_n  = bcnt + 1'b1;
            state_n = (bcnt == B_LAST) ? STOP : DATA;
          end
        end
        STOP: begin
          tcnt_n  = (tcnt == T_END) ? '0 : tcnt + 1'b1;
          load    = tcnt == T_END;
          state_n = (tcnt == T_END) ? IDLE : STOP;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsync  <= '1;
      rsync  <= '1;
      state  <= IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      data_q <= '0;
      flag_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      bsync <= {bsync[1:0], bus.baud_clk};
      rsync <= {rsync[0], bus.ser_in};
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
      // a load in the same cycle as clr_flag takes priority over the clear
      if (load) begin
        data_q <= shreg;
        ferr_q <= ~rx;
        ovr_q  <= flag_q;
        flag_q <= 1'b1;
      end else if (bus.clr_flag) begin
        flag_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_m706_rx.sv
// tb_m706_rx: randomized and directed frames for two receiver configurations against a character-level model.
module tb_m706_rx;
  logic clk = 1'b0, rst_n = 1'b0, baud = 1'b0;
  logic ser0 = 1'b1, ser1 = 1'b1, clr0 = 1'b0, clr1 = 1'b0;
  int   redges = 0, checks = 0, failures = 0;
  logic [7:0] m_data [2];
  logic       m_flag [2], m_fe [2], m_ov [2];
  m706_rx_if #(.DATA_BITS(8)) if0 ();
  m706_rx_if #(.DATA_BITS(7)) if1 ();
  assign if0.baud_clk = baud;
  assign if0.ser_in   = ser0;
  assign if0.clr_flag = clr0;
  assign if1.baud_clk = baud;
  assign if1.ser_in   = ser1;
  assign if1.clr_flag = clr1;
  m706_rx #(.DATA_BITS(8), .OVERSAMPLE(8))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  m706_rx #(.DATA_BITS(7), .OVERSAMPLE(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  always #25 clk = ~clk;
  // baud square wave with 16 clk per period, edges placed on falling clk edges
  initial forever begin
    repeat (8) @(negedge clk);
    baud = 1'b1;
    redges++;
    repeat (8) @(negedge clk);
    baud = 1'b0;
  end
  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end
  function automatic logic [11:0] obs(input int w);
    return (w == 0) ? {if0.data, if0.flag, if0.framing_err, if0.overrun, if0.active}
                    : {1'b0, if1.data, if1.flag, if1.framing_err, if1.overrun, if1.active};
  endfunction
  function automatic logic [11:0] expv(input int w);
    return {m_data[w], m_flag[w], m_fe[w], m_ov[w], 1'b0};
  endfunction
  task automatic drive_bit(input int w, input logic v, input int os);
    if (w == 0) ser0 = v; else ser1 = v;
    repeat (os) @(negedge baud);
  endtask
  task automatic send(input int w, input logic [7:0] c, input logic stop, input int db, input int os, input int gap);
    @(negedge baud);
    drive_bit(w, 1'b0, os);
    for (int i = 0; i < db; i++) drive_bit(w, c[i], os);
    drive_bit(w, stop, os);
    if (w == 0) ser0 = 1'b1; else ser1 = 1'b1;
    repeat (gap * os) @(negedge baud);
    m_ov[w]   = m_flag[w];
    m_flag[w] = 1'b1;
    m_data[w] = (db == 8) ? c : (c & 8'h7f);
    m_fe[w]   = ~stop;
    @(posedge clk);
    #1;
  endtask
  task automatic clear(input int w);
    @(posedge clk);
    #1;
    if (w == 0) clr0 = 1'b1; else clr1 = 1'b1;
    @(posedge clk);
    #1;
    clr0 = 1'b0;
    clr1 = 1'b0;
    m_flag[w] = 1'b0;
    m_ov[w]   = 1'b0;
  endtask
  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_data[w] = '0;
      m_flag[w] = 1'b0;
      m_fe[w]   = 1'b0;
      m_ov[w]   = 1'b0;
    end
  endtask
  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== expv(w)) begin
        failures++;
        $display("FAIL reset_state[%0d]: got %h want %h", w, obs(w), expv(w));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge baud);
  endtask
  task automatic test_nominal();
    fork
      send(0, 8'h55, 1'b1, 8, 8, 1);
      begin
        repeat (20) @(negedge baud);
        #1;
        checks++;
        if (if0.active !== 1'b1) begin
          failures++;
          $display("FAIL nominal_active: got %b want 1", if0.active);
        end
      end
    join
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL nominal_55: got %h want %h", obs(0), expv(0));
    end
  endtask
  task automatic test_glitch();
    clear(0);
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL glitch_preclear: got %h want %h", obs(0), expv(0));
    end
    @(negedge baud);
    ser0 = 1'b0;
    repeat (2) @(negedge baud);
    ser0 = 1'b1;
    #1;
    checks++;
    if (if0.active !== 1'b1) begin
      failures++;
      $display("FAIL glitch_active: got %b want 1", if0.active);
    end
    repeat (8) @(negedge baud);
    #1;
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL glitch_ignored: got %h want %h", obs(0), expv(0));
    end
  endtask
  task automatic test_framing();
    send(0, 8'hA3, 1'b0, 8, 8, 2);
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL framing_bad_stop: got %h want %h", obs(0), expv(0));
    end
    send(0, 8'h01, 1'b1, 8, 8, 1);
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL framing_recover: got %h want %h", obs(0), expv(0));
    end
  endtask
  task automatic test_overrun_clear();
    logic pre;
    int   target;
    clear(0);
    send(0, 8'h41, 1'b1, 8, 8, 1);
    send(0, 8'h42, 1'b1, 8, 8, 1);
    checks++;
    if (obs(0) !== expv(0) || if0.overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %h want %h", obs(0), expv(0));
    end
    clear(0);
    checks++;
    if (obs(0) !== expv(0) || if0.flag !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: got %h want %h", obs(0), expv(0));
    end
    send(0, 8'h43, 1'b1, 8, 8, 1);
    pre = m_flag[0];
    fork
      send(0, 8'h44, 1'b1, 8, 8, 1);
      begin
        @(negedge ser0);
        target = redges + 1 + 4 + 9 * 8;
        wait (redges == target);
        @(posedge clk);
        @(posedge clk);
        #1;
        clr0 = 1'b1;
        @(posedge clk);
        #1;
        clr0 = 1'b0;
        checks++;
        if ({if0.flag, if0.overrun, if0.data} !== {1'b1, pre, 8'h44}) begin
          failures++;
          $display("FAIL clear_vs_load: got f=%b ov=%b d=%h want f=1 ov=%b d=44", if0.flag, if0.overrun, if0.data, pre);
        end
      end
    join
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL clear_vs_load_after: got %h want %h", obs(0), expv(0));
    end
  endtask
  task automatic test_reset_mid();
    @(negedge baud);
    drive_bit(0, 1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 8);
    repeat (3) @(negedge baud);
    @(posedge clk);
    #10;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs(0) !== expv(0) || obs(1) !== expv(1)) begin
      failures++;
      $display("FAIL reset_mid: got %h/%h want %h/%h", obs(0), obs(1), expv(0), expv(1));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge baud);
    send(0, 8'h0F, 1'b1, 8, 8, 1);
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL reset_mid_next: got %h want %h", obs(0), expv(0));
    end
  endtask
  task automatic test_timing7();
    int target;
    fork
      send(1, 8'h7F, 1'b1, 7, 16, 1);
      begin
        @(negedge ser1);
        target = redges + 1 + 8 + 8 * 16;
        wait (redges == target);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (if1.flag !== 1'b0) begin
          failures++;
          $display("FAIL timing7_early: got flag=%b want 0", if1.flag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if1.flag !== 1'b1) begin
          failures++;
          $display("FAIL timing7_rise: got flag=%b want 1", if1.flag);
        end
      end
    join
    checks++;
    if (obs(1) !== expv(1)) begin
      failures++;
      $display("FAIL timing7_data: got %h want %h", obs(1), expv(1));
    end
  endtask
  task automatic test_back_to_back();
    clear(0);
    send(0, 8'hC6, 1'b1, 8, 8, 0);
    send(0, 8'h39, 1'b1, 8, 8, 1);
    checks++;
    if (obs(0) !== expv(0)) begin
      failures++;
      $display("FAIL back_to_back: got %h want %h", obs(0), expv(0));
    end
  endtask
  task automatic test_random();
    logic [7:0] c;
    logic       stop;
    int         gap;
    for (int n = 0; n < 10; n++) begin
      c    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if ($urandom_range(0, 1) == 1) clear(0);
      send(0, c, stop, 8, 8, gap);
      checks++;
      if (obs(0) !== expv(0)) begin
        failures++;
        $display("FAIL random[%0d]: got %h want %h", n, obs(0), expv(0));
      end
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_overrun_clear();
    test_reset_mid();
    test_timing7();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
